// File: rtl/tick_period_monitor_if.sv
// Bundle of the control and result signals of tick_period_monitor.
// The master side arms a measurement and feeds the tick stream, the slave
// side (the monitor) reports status and the measured period.
interface tick_period_monitor_if #(
  parameter int CNT_W = 24
);
  logic             en;
  logic             tick_in;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic             ok;
  logic             timeout;

  modport master (
    output en, tick_in, start,
    input  busy, done, period, ok, timeout
  );

  modport slave (
    input  en, tick_in, start,
    output busy, done, period, ok, timeout
  );
endinterface

// File: rtl/tick_period_monitor.sv
// Single-shot tick period monitor: after start it waits for an opening rising
// edge of tick_in, counts enabled clk cycles to the next rising edge and
// reports the spacing, whether it lies within TOL of EXPECTED, and whether
// the counter saturated before the closing edge arrived.
// The interface instance must be built with the same CNT_W as this module.
module tick_period_monitor #(
  parameter int CNT_W    = 24,
  parameter int EXPECTED = 10,
  parameter int TOL      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tick_period_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   EXP_EXT = (CNT_W+1)'(EXPECTED);
  localparam logic [CNT_W:0]   TOL_EXT = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]   ONE_EXT = (CNT_W+1)'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tick_q;
  logic             rise;
  logic [CNT_W-1:0] period_q;
  logic             ok_q;
  logic             timeout_q;
  logic             load;
  logic [CNT_W-1:0] period_nxt;
  logic             ok_nxt;
  logic             timeout_nxt;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   mag;
  logic             in_tol;

  assign rise = bus.tick_in & ~tick_q;

  // One extra bit keeps the signed difference from wrapping for any period.
  assign diff   = {1'b0, cnt} - EXP_EXT;
  assign mag    = diff[CNT_W] ? (~diff + ONE_EXT) : diff;
  assign in_tol = (mag <= TOL_EXT);

  // Next state, counter and result; saturation wins over a closing edge so
  // the largest measurable spacing is one below the counter maximum.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    load        = 1'b0;
    period_nxt  = period_q;
    ok_nxt      = ok_q;
    timeout_nxt = timeout_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ARM;
          cnt_nxt   = CNT_ONE;
        end
      end
      ARM: begin
        if (rise) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = DONE;
          load        = 1'b1;
          period_nxt  = CNT_MAX;
          ok_nxt      = 1'b0;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      MEASURE: begin
        if (cnt == CNT_MAX) begin
          state_nxt   = DONE;
          load        = 1'b1;
          period_nxt  = CNT_MAX;
          ok_nxt      = 1'b0;
          timeout_nxt = 1'b1;
        end else if (rise) begin
          state_nxt   = DONE;
          load        = 1'b1;
          period_nxt  = cnt;
          ok_nxt      = in_tol;
          timeout_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter, edge register and held result; everything freezes while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tick_q    <= 1'b0;
      period_q  <= '0;
      ok_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else if (bus.en) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tick_q <= bus.tick_in;
      if (load) begin
        period_q  <= period_nxt;
        ok_q      <= ok_nxt;
        timeout_q <= timeout_nxt;
      end
    end
  end

  assign bus.busy    = (state == ARM) || (state == MEASURE);
  assign bus.done    = (state == DONE);
  assign bus.period  = period_q;
  assign bus.ok      = ok_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Self-checking bench for tick_period_monitor. Four monitors with different
// counter widths and tolerances share one stimulus stream; a timestamp-based
// reference model predicts every output on every cycle.
module tb_tick_period_monitor;

  localparam int N   = 4;
  localparam int EXP = 10;
  localparam int W_OF   [N] = '{4, 4, 4, 8};
  localparam int TOL_OF [N] = '{0, 1, 2, 0};

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b1;
  logic tick_in = 1'b0;
  logic start   = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt  [N];
  int done_base [N];

  always #5 clk = ~clk;

  tick_period_monitor_if #(.CNT_W(4)) b0 ();
  tick_period_monitor_if #(.CNT_W(4)) b1 ();
  tick_period_monitor_if #(.CNT_W(4)) b2 ();
  tick_period_monitor_if #(.CNT_W(8)) b3 ();

  assign b0.en = en;  assign b0.tick_in = tick_in;  assign b0.start = start;
  assign b1.en = en;  assign b1.tick_in = tick_in;  assign b1.start = start;
  assign b2.en = en;  assign b2.tick_in = tick_in;  assign b2.start = start;
  assign b3.en = en;  assign b3.tick_in = tick_in;  assign b3.start = start;

  tick_period_monitor #(.CNT_W(4), .EXPECTED(EXP), .TOL(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  tick_period_monitor #(.CNT_W(4), .EXPECTED(EXP), .TOL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  tick_period_monitor #(.CNT_W(4), .EXPECTED(EXP), .TOL(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  tick_period_monitor #(.CNT_W(8), .EXPECTED(EXP), .TOL(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  logic [31:0] act_period [N];
  logic        act_busy   [N];
  logic        act_done   [N];
  logic        act_ok     [N];
  logic        act_to     [N];

  assign act_period[0] = 32'(b0.period);  assign act_busy[0] = b0.busy;  assign act_done[0] = b0.done;
  assign act_period[1] = 32'(b1.period);  assign act_busy[1] = b1.busy;  assign act_done[1] = b1.done;
  assign act_period[2] = 32'(b2.period);  assign act_busy[2] = b2.busy;  assign act_done[2] = b2.done;
  assign act_period[3] = 32'(b3.period);  assign act_busy[3] = b3.busy;  assign act_done[3] = b3.done;
  assign act_ok[0] = b0.ok;  assign act_to[0] = b0.timeout;
  assign act_ok[1] = b1.ok;  assign act_to[1] = b1.timeout;
  assign act_ok[2] = b2.ok;  assign act_to[2] = b2.timeout;
  assign act_ok[3] = b3.ok;  assign act_to[3] = b3.timeout;

  // Reference model: phase 0 idle, 1 waiting for opening edge, 2 timing, 3 result cycle.
  // Time is kept as a count of enabled cycles; spacings are timestamp differences.
  typedef struct {
    int     phase;
    bit     tick_prev;
    longint cur;
    longint ref_idx;
    longint per;
    bit     ok;
    bit     to;
  } model_t;

  model_t mdl [N];

  function automatic void model_reset(input int i);
    mdl[i].phase     = 0;
    mdl[i].tick_prev = 1'b0;
    mdl[i].cur       = 0;
    mdl[i].ref_idx   = 0;
    mdl[i].per       = 0;
    mdl[i].ok        = 1'b0;
    mdl[i].to        = 1'b0;
  endfunction

  function automatic void model_step(input int i);
    longint maxc;
    longint el;
    longint dev;
    bit     rise;
    maxc = (longint'(1) << W_OF[i]) - 1;
    rise = tick_in && !mdl[i].tick_prev;
    mdl[i].tick_prev = tick_in;
    el = mdl[i].cur - mdl[i].ref_idx;
    case (mdl[i].phase)
      0: if (start) begin
        mdl[i].phase   = 1;
        mdl[i].ref_idx = mdl[i].cur;
      end
      1: if (rise) begin
        mdl[i].phase   = 2;
        mdl[i].ref_idx = mdl[i].cur;
      end else if (el == maxc) begin
        mdl[i].phase = 3;  mdl[i].per = maxc;  mdl[i].ok = 1'b0;  mdl[i].to = 1'b1;
      end
      2: if (el == maxc) begin
        mdl[i].phase = 3;  mdl[i].per = maxc;  mdl[i].ok = 1'b0;  mdl[i].to = 1'b1;
      end else if (rise) begin
        dev = (el > EXP) ? (el - EXP) : (EXP - el);
        mdl[i].phase = 3;  mdl[i].per = el;  mdl[i].to = 1'b0;
        mdl[i].ok    = (dev <= TOL_OF[i]);
      end
      default: mdl[i].phase = 0;
    endcase
    mdl[i].cur++;
  endfunction

  function automatic void check_output(input string nm, input int i, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s u%0d: got %0d, expected %0d at %0t", nm, i, act, exp, $time);
    end
  endfunction

  // Advance the model alongside the DUTs, with the same asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) model_reset(i);
    end else if (en) begin
      for (int i = 0; i < N; i++) model_step(i);
    end
  end

  // Compare every output of every instance one step after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      check_output("busy",    i, longint'(act_busy[i]), longint'(mdl[i].phase == 1 || mdl[i].phase == 2));
      check_output("done",    i, longint'(act_done[i]), longint'(mdl[i].phase == 3));
      check_output("period",  i, longint'(act_period[i]), mdl[i].per);
      check_output("ok",      i, longint'(act_ok[i]), longint'(mdl[i].ok));
      check_output("timeout", i, longint'(act_to[i]), longint'(mdl[i].to));
      if (act_done[i]) done_cnt[i]++;
    end
  end

  // Drive one run: start at offset 0 (plus optional restart), a tick train of
  // 1-cycle pulses, an optional extra pulse and an optional en-low window.
  task automatic apply_stimulus(input int p, input int first, input int n_ticks,
                                input int gap_at, input int gap_len, input int extra_tick,
                                input int restart_at, input int len, input bit hold_high);
    for (int i = 0; i < N; i++) done_base[i] = done_cnt[i];
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      start   = (k == 0) || (k == restart_at);
      en      = !(k >= gap_at && k < gap_at + gap_len);
      tick_in = hold_high || (k == extra_tick) ||
                (n_ticks > 0 && k >= first && ((k - first) % p) == 0 && ((k - first) / p) < n_ticks);
    end
    @(negedge clk);
    start   = 1'b0;
    en      = 1'b1;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_result(input string nm, input int i, input longint per,
                              input bit ok_e, input bit to_e);
    check_output({nm, "_period"},  i, longint'(act_period[i]), per);
    check_output({nm, "_ok"},      i, longint'(act_ok[i]), longint'(ok_e));
    check_output({nm, "_timeout"}, i, longint'(act_to[i]), longint'(to_e));
    check_output({nm, "_dones"},   i, longint'(done_cnt[i] - done_base[i]), 1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      done_cnt[i]  = 0;
      done_base[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_output("rst_period", i, longint'(act_period[i]), 0);
      check_output("rst_busy",   i, longint'(act_busy[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed runs");
    apply_stimulus(10, 2, 2, -1, 0, -1, -1, 16, 1'b0);
    check_result("p10", 0, 10, 1'b1, 1'b0);
    check_result("p10", 3, 10, 1'b1, 1'b0);

    apply_stimulus(12, 2, 2, -1, 0, -1, -1, 18, 1'b0);
    check_result("p12", 1, 12, 1'b0, 1'b0);
    check_result("p12", 2, 12, 1'b1, 1'b0);

    apply_stimulus(8, 2, 2, -1, 0, -1, -1, 14, 1'b0);
    check_result("p8", 1, 8, 1'b0, 1'b0);
    check_result("p8", 2, 8, 1'b1, 1'b0);

    apply_stimulus(10, 2, 0, -1, 0, -1, -1, 270, 1'b0);
    check_result("to_low", 0, 15, 1'b0, 1'b1);
    check_result("to_low", 3, 255, 1'b0, 1'b1);

    apply_stimulus(10, 2, 0, -1, 0, -1, -1, 270, 1'b1);
    check_result("to_high", 0, 15, 1'b0, 1'b1);
    check_result("to_high", 3, 255, 1'b0, 1'b1);

    apply_stimulus(10, 2, 2, 5, 3, -1, -1, 18, 1'b0);
    check_result("en_gap", 0, 7, 1'b0, 1'b0);

    apply_stimulus(10, 2, 2, 4, 3, 5, -1, 18, 1'b0);
    check_result("lost_edge", 3, 7, 1'b0, 1'b0);

    apply_stimulus(10, 2, 2, -1, 0, -1, -1, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check_output("mid_rst_busy",   i, longint'(act_busy[i]), 0);
      check_output("mid_rst_done",   i, longint'(act_done[i]), 0);
      check_output("mid_rst_period", i, longint'(act_period[i]), 0);
      check_output("mid_rst_ok",     i, longint'(act_ok[i]), 0);
      check_output("mid_rst_to",     i, longint'(act_to[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(10, 2, 2, -1, 0, -1, -1, 16, 1'b0);
    check_result("after_rst", 0, 10, 1'b1, 1'b0);

    apply_stimulus(10, 2, 2, -1, 0, -1, 5, 18, 1'b0);
    check_result("restart", 0, 10, 1'b1, 1'b0);

    apply_stimulus(10, 6, 2, -1, 0, 0, -1, 20, 1'b0);
    check_result("coincident", 0, 10, 1'b1, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 40; r++) begin
      int p, first, nt, gap_at, gap_len, extra, restart, len;
      p       = $urandom_range(2, 16);
      first   = $urandom_range(1, 5);
      nt      = $urandom_range(1, 3);
      gap_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
      gap_len = $urandom_range(1, 4);
      extra   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 25) : -1;
      restart = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
      len     = first + p * nt + $urandom_range(0, 6);
      apply_stimulus(p, first, nt, gap_at, gap_len, extra, restart, len, 1'b0);
    end

    $display("[TB] random noise");
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      tick_in = ($urandom_range(0, 3) == 0);
      start   = ($urandom_range(0, 7) == 0);
      en      = ($urandom_range(0, 5) != 0);
      rst_n   = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    en      = 1'b1;
    start   = 1'b0;
    tick_in = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
